// File: rtl/des_3des_iterative_engine.sv
// Iterative DES / 3DES-EDE block engine, ROUNDS_PER_CYCLE chained rounds per clock.
// Latency: passes*16/ROUNDS_PER_CYCLE cycles from the acceptance edge to out_valid.
// Backpressure: one block in flight; in_ready only when idle, result held until out_ready.
// Ports: clk/n_rst; request in_valid/in_ready/in_block/mode_3des/decrypt;
//        round_keys_k1..k3 (16x48, index 0 = round 1, not registered, held by requester);
//        result out_valid/out_ready/out_block. Blocks use DES bit numbering (bit 1 = MSB).
module des_3des_iterative_engine #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int ENABLE_3DES      = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_block,
  input  logic              mode_3des,
  input  logic              decrypt,
  input  logic [15:0][47:0] round_keys_k1,
  input  logic [15:0][47:0] round_keys_k2,
  input  logic [15:0][47:0] round_keys_k3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_block
);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box: 64 nibbles, row-major (row = b1b6, col = b2..b5), entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [3:0] sbox_f(input logic [2:0] n, input logic [5:0] b);
    logic [5:0]   idx;
    logic [255:0] tbl;
    idx = {b[5], b[0], b[4:1]};
    // ~idx == 63 - idx: shifts entry idx down into the low nibble
    tbl = SBOX[n] >> {~idx, 2'b00};
    return tbl[3:0];
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    e = '0;
    s = '0;
    y = '0;
    // Expansion: group g takes DES bits 4g..4g+5 (1-based, wrapping 33 -> 1, 0 -> 32)
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < 6; j++)
        e[6'(47 - 6*g - j)] = r[5'(31 - ((4*g + j + 31) % 32))];
    e = e ^ k;
    for (int g = 0; g < 8; g++)
      s[5'(31 - 4*g) -: 4] = sbox_f(3'(g), e[6'(47 - 6*g) -: 6]);
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
    return y;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_nx;
  logic [31:0]       l_q, r_q, l_nx, r_nx, t_c;
  logic [3:0]        rnd_q, rn_c, kidx_c;
  logic [1:0]        pass_q;
  logic              mode_q, dec_q;
  logic              accept, pass_dec, last_rounds, final_pass;
  logic [15:0][47:0] ks;

  assign accept      = in_valid && (state_q == IDLE);
  assign last_rounds = (rnd_q == 4'(16 - ROUNDS_PER_CYCLE));
  assign final_pass  = (pass_q == (mode_q ? 2'd2 : 2'd0));
  // EDE: the middle pass runs opposite to the requested direction
  assign pass_dec    = dec_q ^ (pass_q == 2'd1);

  // Key set per pass: encrypt K1,K2,K3; decrypt K3,K2,K1; single DES K1.
  always_comb begin
    ks = round_keys_k1;
    if (pass_q == 2'd1)
      ks = round_keys_k2;
    else if (pass_q == 2'd0)
      ks = (mode_q && dec_q) ? round_keys_k3 : round_keys_k1;
    else
      ks = dec_q ? round_keys_k1 : round_keys_k3;
  end

  always_comb begin
    l_nx   = l_q;
    r_nx   = r_q;
    rn_c   = '0;
    kidx_c = '0;
    t_c    = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rn_c   = rnd_q + 4'(j);
      kidx_c = pass_dec ? (4'd15 - rn_c) : rn_c;
      t_c    = l_nx ^ des_f(r_nx, ks[kidx_c]);
      l_nx   = r_nx;
      r_nx   = t_c;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last_rounds && final_pass) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      l_q       <= '0;
      r_q       <= '0;
      rnd_q     <= '0;
      pass_q    <= '0;
      mode_q    <= 1'b0;
      dec_q     <= 1'b0;
      out_block <= '0;
    end else if (accept) begin
      {l_q, r_q} <= ip_f(in_block);
      rnd_q      <= '0;
      pass_q     <= '0;
      mode_q     <= (ENABLE_3DES != 0) && mode_3des;
      dec_q      <= decrypt;
    end else if (state_q == RUN) begin
      if (last_rounds) begin
        // Swapped halves feed the next pass directly: FP then IP would cancel.
        l_q   <= r_nx;
        r_q   <= l_nx;
        rnd_q <= '0;
        if (final_pass) out_block <= fp_f({r_nx, l_nx});
        else            pass_q    <= pass_q + 2'd1;
      end else begin
        l_q   <= l_nx;
        r_q   <= r_nx;
        rnd_q <= rnd_q + 4'(ROUNDS_PER_CYCLE);
      end
    end
  end

endmodule

// File: tb/tb_des_3des_iterative_engine.sv
// Bench: five engine instances (1, 2, 4, 8, 16 rounds per cycle) driven one at a time.
module tb_des_3des_iterative_engine;

  localparam int ND = 5;
  localparam logic [63:0] KA = 64'h133457799BBCDFF1;
  localparam logic [63:0] KB = 64'h0E329232EA6D0D73;
  localparam logic [63:0] KC = 64'hFEDCBA9876543210;
  localparam logic [63:0] P0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C0 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h8787878787878787;
  localparam logic [63:0] C1 = 64'h0000000000000000;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic        m3;
    logic        dec;
    logic [63:0] k1, k2, k3, pin, pexp;
  } vec_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [ND-1:0]     in_valid, in_ready, out_valid, out_ready;
  logic [63:0]       in_block;
  logic              mode_3des, decrypt;
  logic [15:0][47:0] k1s, k2s, k3s;
  logic [63:0]       out_blk [ND];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    des_3des_iterative_engine #(.ROUNDS_PER_CYCLE(1 << g), .ENABLE_3DES(1)) u_dut (
      .clk(clk), .n_rst(n_rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_block(in_block),
      .mode_3des(mode_3des), .decrypt(decrypt),
      .round_keys_k1(k1s), .round_keys_k2(k2s), .round_keys_k3(k3s),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_block(out_blk[g]));
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic key_sched(input logic [63:0] key, output logic [15:0][47:0] ks);
    logic [55:0] cd;
    logic [27:0] c, d;
    ks = '0;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[r][47 - i] = cd[56 - PC2[i]];
    end
  endtask

  task automatic set_keys(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    key_sched(a, k1s);
    key_sched(b, k2s);
    key_sched(c, k3s);
  endtask

  // Starts just after an acceptance edge; counts edges until out_valid (bounded).
  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Entered and left 1 ns after a rising edge.
  task automatic run_op(input int d, input logic m3, input logic dec, input logic [63:0] blk,
                        input logic [63:0] exp_blk, input bit cmp, input string tag,
                        output logic [63:0] got);
    int lat;
    in_block     = blk;
    mode_3des    = m3;
    decrypt      = dec;
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b1;
    chk({tag, " in_ready idle"}, 64'(in_ready[d]), 64'd1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_block    = ~blk;   // request fields must have been captured
    mode_3des   = ~m3;
    decrypt     = ~dec;
    chk({tag, " in_ready busy"}, 64'(in_ready[d]), 64'd0);
    wait_done(d, lat);
    chk({tag, " latency"}, 64'(lat), 64'(((m3 ? 3 : 1) * 16) >> d));
    got = out_blk[d];
    if (cmp) chk({tag, " result"}, got, exp_blk);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk({tag, " out_valid cleared"}, 64'(out_valid[d]), 64'd0);
  endtask

  vec_t        vecs [10];
  logic [63:0] got, c_ref, c_rt;
  int          lat;

  initial begin
    vecs[0] = '{1'b0, 1'b0, KA, KA, KA, P0, C0};
    vecs[1] = '{1'b0, 1'b1, KA, KA, KA, C0, P0};
    vecs[2] = '{1'b1, 1'b0, KA, KA, KA, P0, C0};
    vecs[3] = '{1'b1, 1'b1, KA, KA, KA, C0, P0};
    vecs[4] = '{1'b0, 1'b0, KB, KA, KA, P1, C1};
    vecs[5] = '{1'b0, 1'b1, KB, KA, KA, C1, P1};
    vecs[6] = '{1'b1, 1'b0, KA, KA, KB, P1, C1};   // E(K1) D(K1) cancel -> E(K3)
    vecs[7] = '{1'b1, 1'b1, KA, KA, KB, C1, P1};
    vecs[8] = '{1'b1, 1'b0, KB, KA, KA, P1, C1};   // D(K2) E(K3) cancel -> E(K1)
    vecs[9] = '{1'b1, 1'b1, KB, KA, KA, C1, P1};

    n_rst     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    in_block  = '0;
    mode_3des = 1'b0;
    decrypt   = 1'b0;
    k1s = '0; k2s = '0; k3s = '0;
    #12;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst out_valid d%0d", d), 64'(out_valid[d]), 64'd0);
      chk($sformatf("rst out_block d%0d", d), out_blk[d], 64'd0);
      chk($sformatf("rst in_ready d%0d", d), 64'(in_ready[d]), 64'd1);
    end
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors on every rounds-per-cycle variant
    for (int d = 0; d < ND; d++)
      for (int v = 0; v < 10; v++) begin
        set_keys(vecs[v].k1, vecs[v].k2, vecs[v].k3);
        run_op(d, vecs[v].m3, vecs[v].dec, vecs[v].pin, vecs[v].pexp, 1'b1,
               $sformatf("vec%0d rpc%0d", v, 1 << d), got);
      end

    // 3DES round trip with three distinct keys; ciphertext identical across variants
    set_keys(KA, KB, KC);
    c_ref = '0;
    for (int d = 0; d < ND; d++) begin
      run_op(d, 1'b1, 1'b0, P0, 64'd0, 1'b0, $sformatf("rt enc rpc%0d", 1 << d), c_rt);
      if (d == 0) begin
        c_ref = c_rt;
        checks++;
        if (c_rt === P0 || c_rt === C0) begin
          errors++;
          $display("FAIL rt cipher: got %h must differ from %h and %h", c_rt, P0, C0);
        end
      end else begin
        chk($sformatf("rt same cipher rpc%0d", 1 << d), c_rt, c_ref);
      end
      run_op(d, 1'b1, 1'b1, c_rt, P0, 1'b1, $sformatf("rt dec rpc%0d", 1 << d), got);
    end

    // Backpressure: result held, input ignored, no acceptance in the handshake cycle
    set_keys(KA, KA, KA);
    for (int d = 0; d < ND; d++) begin
      in_block    = P0;
      mode_3des   = 1'b0;
      decrypt     = 1'b0;
      in_valid[d] = 1'b1;            // kept high through RUN and DONE
      @(posedge clk); #1;
      wait_done(d, lat);
      chk($sformatf("bp latency rpc%0d", 1 << d), 64'(lat), 64'(16 >> d));
      for (int c = 0; c < 10; c++) begin
        chk($sformatf("bp hold out_block rpc%0d c%0d", 1 << d, c), out_blk[d], C0);
        chk($sformatf("bp hold valid/ready rpc%0d c%0d", 1 << d, c),
            64'({out_valid[d], in_ready[d]}), 64'b10);
        @(posedge clk); #1;
      end
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
      chk($sformatf("bp handshake idle rpc%0d", 1 << d),
          64'({out_valid[d], in_ready[d]}), 64'b01);
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      chk($sformatf("bp next accept rpc%0d", 1 << d), 64'(in_ready[d]), 64'd0);
      wait_done(d, lat);
      chk($sformatf("bp next latency rpc%0d", 1 << d), 64'(lat), 64'(16 >> d));
      chk($sformatf("bp next result rpc%0d", 1 << d), out_blk[d], C0);
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
    end

    // Reset in the middle of the second pass (round 7) of a 3DES encrypt
    set_keys(KA, KA, KA);
    in_block    = P0;
    mode_3des   = 1'b1;
    decrypt     = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (16 + 7) @(posedge clk);
    #1;
    chk("rst-mid out_block before reset", out_blk[0], C0);
    n_rst = 1'b0;
    #1;
    chk("rst-mid out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst-mid out_block", out_blk[0], 64'd0);
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("rst-mid first edge accept", 64'(in_ready[0]), 64'd0);
    wait_done(0, lat);
    chk("rst-mid latency", 64'(lat), 64'd48);
    chk("rst-mid result", out_blk[0], C0);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
